// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller.
//   Arbitrates between the load/store buffer (mc_*) and instruction fetch
//   (if_*), breaks each request into single-byte accesses on a synchronous
//   byte-wide RAM/IO bus, and returns assembled read data with a one-cycle
//   done pulse.
// Ports:
//   clk, rst (async, active high), rdy (global enable), rollback (flush)
//   mc_en/mc_wr/mc_addr/mc_len/mc_w_data -> mc_done/mc_r_data   (LSB side)
//   if_en/if_addr                         -> if_done/if_data     (fetch side)
//   mem_din (read byte, one cycle after its address), mem_dout, mem_a, mem_wr
//   io_buffer_full (IO output FIFO full)
// Optional feature macro: MEM_CTRL_IO_THROTTLE_EN
//   When defined, stores into the IO region (addr[17:16] == IO_TAG) only
//   issue a byte while io_buffer_full is low, and every IO byte is followed
//   by one idle bus cycle.
module mem_ctrl #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_TAG     = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic                  mc_en,
  input  logic                  mc_wr,
  input  logic [ADDR_WIDTH-1:0] mc_addr,
  input  logic [2:0]            mc_len,
  input  logic [31:0]           mc_w_data,
  output logic                  mc_done,
  output logic [31:0]           mc_r_data,
  input  logic                  if_en,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IF_READ, LSB_READ, LSB_WRITE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [2:0]            len_q, len_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [31:0]           mc_r_data_q, mc_r_data_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mc_done_q, mc_done_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_wr_q, mem_wr_d;

  // Reads: cnt_q counts edges since acceptance, so nxt is the index of the
  // current edge. Writes: cnt_q is the index of the next byte to issue.
  logic [2:0]            nxt;
  logic [1:0]            rd_idx;
  logic [7:0]            wr_byte;
  logic [ADDR_WIDTH-1:0] nxt_addr, cur_addr;

  assign nxt      = cnt_q + 3'd1;
  assign rd_idx   = 2'(cnt_q - 3'd1);   // byte arriving on this edge
  assign wr_byte  = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
  assign nxt_addr = addr_q + ADDR_WIDTH'(nxt);
  assign cur_addr = addr_q + ADDR_WIDTH'(cnt_q);

  // Only 1 and 2 are short accesses; everything else is a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] l);
    case (l)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

`ifdef MEM_CTRL_IO_THROTTLE_EN
  logic acc_io, cur_io;
  assign acc_io = (mc_addr[17:16] == IO_TAG);
  assign cur_io = (addr_q[17:16] == IO_TAG);
`else
  logic unused_io;
  assign unused_io = io_buffer_full ^ (^IO_TAG);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    mc_r_data_d = mc_r_data_q;
    if_data_d   = if_data_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    mc_done_d   = 1'b0;
    if_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A committed store is accepted even during rollback.
        if (mc_en && mc_wr) begin
          state_d    = LSB_WRITE;
          addr_d     = mc_addr;
          len_d      = norm_len(mc_len);
          wdata_d    = mc_w_data;
          mem_a_d    = mc_addr;
          mem_dout_d = mc_w_data[7:0];
          mem_wr_d   = 1'b1;
          cnt_d      = 3'd1;
`ifdef MEM_CTRL_IO_THROTTLE_EN
          if (acc_io && io_buffer_full) begin
            mem_wr_d = 1'b0;
            cnt_d    = 3'd0;
          end
`endif
        end else if (mc_en && !rollback) begin
          state_d = LSB_READ;
          addr_d  = mc_addr;
          len_d   = norm_len(mc_len);
          mem_a_d = mc_addr;
          cnt_d   = 3'd0;
          rbuf_d  = '0;
        end else if (if_en && !rollback) begin
          state_d = IF_READ;
          addr_d  = if_addr;
          len_d   = 3'd4;
          mem_a_d = if_addr;
          cnt_d   = 3'd0;
          rbuf_d  = '0;
        end
      end
      IF_READ, LSB_READ: begin
        if (rollback) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = nxt;
          // Addresses run one edge ahead of captured data; mem_a parks on
          // the last byte address.
          if (nxt < len_q) mem_a_d = nxt_addr;
          if (nxt >= 3'd2) rbuf_d[{rd_idx, 3'b000} +: 8] = mem_din;
          if (nxt == len_q + 3'd1) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (state_q == IF_READ) begin
              if_data_d = rbuf_d;
              if_done_d = 1'b1;
            end else begin
              mc_r_data_d = rbuf_d;
              mc_done_d   = 1'b1;
            end
          end
        end
      end
      LSB_WRITE: begin
`ifdef MEM_CTRL_IO_THROTTLE_EN
        // IO stores: issue only when the FIFO has room, and always leave
        // one dead cycle after each byte.
        if (cur_io) begin
          if (mem_wr_q) begin
            mem_wr_d = 1'b0;
            if (cnt_q == len_q) begin
              state_d   = IDLE;
              cnt_d     = 3'd0;
              mc_done_d = 1'b1;
            end
          end else if (!io_buffer_full) begin
            mem_a_d    = cur_addr;
            mem_dout_d = wr_byte;
            mem_wr_d   = 1'b1;
            cnt_d      = nxt;
          end
        end else
`endif
        if (cnt_q < len_q) begin
          mem_a_d    = cur_addr;
          mem_dout_d = wr_byte;
          cnt_d      = nxt;
        end else begin
          mem_wr_d  = 1'b0;
          mc_done_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      mc_r_data_q <= '0;
      if_data_q   <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      mc_done_q   <= 1'b0;
      if_done_q   <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      mc_r_data_q <= mc_r_data_d;
      if_data_q   <= if_data_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      mc_done_q   <= mc_done_d;
      if_done_q   <= if_done_d;
    end
  end

  assign mc_done   = mc_done_q;
  assign mc_r_data = mc_r_data_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  // A stalled cycle must never produce a write strobe.
  assign mem_wr    = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: directed scenarios plus randomized traffic checked
// against a byte-array memory model and per-request expected results.
module tb_mem_ctrl;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, rdy, rollback;
  logic          mc_en, mc_wr;
  logic [AW-1:0] mc_addr;
  logic [2:0]    mc_len;
  logic [31:0]   mc_w_data;
  logic          mc_done;
  logic [31:0]   mc_r_data;
  logic          if_en;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [31:0]   if_data;
  logic [7:0]    mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr, io_buffer_full;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(AW), .IO_TAG(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_w_data(mc_w_data), .mc_done(mc_done), .mc_r_data(mc_r_data),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Synchronous RAM, 4 KiB window (address modulo 4096), frozen when rdy low.
  logic [7:0]  ram     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [7:0]  din_q;
  logic        fill, bk_we;
  logic [11:0] bk_a;
  logic [7:0]  bk_d;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'((i * 37 + 5) & 255);
    end else if (bk_we) begin
      ram[bk_a] <= bk_d;
    end else if (rdy && mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
    if (rdy) din_q <= ram[mem_a[11:0]];
  end
  assign mem_din = din_q;

  // Bus monitors, sampled mid-cycle.
  logic [39:0] wq[$];
  logic [31:0] aq[$];
  int mcd_cnt = 0, ifd_cnt = 0;
  always @(negedge clk) begin
    if (mem_wr) wq.push_back({mem_a, mem_dout});
    if (mc_done && rdy) mcd_cnt <= mcd_cnt + 1;
    if (if_done && rdy) ifd_cnt <= ifd_cnt + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    bk_a = a; bk_d = d; bk_we = 1'b1;
    tick;
    bk_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic int nlen(input logic [2:0] l);
    return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[12'(a + 32'(i))];
    return r;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[12'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  // Issue one request and wait for its done pulse. lat = edges after the
  // accepting edge until done is visible (valid when rdy stays high).
  task automatic req(input bit is_if, input bit wr, input logic [31:0] a,
                     input logic [2:0] len, input logic [31:0] wd,
                     input int full_ticks, input bit rnd, input int rb_lo,
                     input int rb_hi, output logic [31:0] rd, output int lat);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    if (is_if) begin
      if_en = 1'b1; if_addr = a;
    end else begin
      mc_en = 1'b1; mc_wr = wr; mc_addr = a; mc_len = len; mc_w_data = wd;
    end
    io_buffer_full = (full_ticks > 0);
    rollback = (rb_lo == 0 && rb_hi > 0);
    aq.delete();
    while (!got && cyc < 200) begin
      tick;
      cyc++;
      aq.push_back(mem_a);
      io_buffer_full = (cyc < full_ticks);
      rollback = (cyc >= rb_lo && cyc < rb_hi);
      got = is_if ? if_done : mc_done;
      if (rnd && !got) rdy = ($urandom_range(0, 7) != 0);
    end
    rdy = 1'b1;
    rollback = 1'b0;
    io_buffer_full = 1'b0;
    chk(is_if ? "if_timeout" : "mc_timeout", got, 1);
    rd  = is_if ? if_data : mc_r_data;
    lat = cyc - 1;
    if (is_if) if_en = 1'b0; else mc_en = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, snap, cyc;

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; mc_en = 1'b0; mc_wr = 1'b0;
    mc_addr = '0; mc_len = '0; mc_w_data = '0; if_en = 1'b0; if_addr = '0;
    io_buffer_full = 1'b0; fill = 1'b1; bk_we = 1'b0; bk_a = '0; bk_d = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
    tick;
    fill = 1'b0;

    chk("rst_flags", {mc_done, if_done, mem_wr}, 0);
    chk("rst_mc_r_data", mc_r_data, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);

    poke(12'h100, 8'h11); poke(12'h101, 8'h22);
    poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    rst = 1'b0;
    tick;

    // LW 0x100
    req(0, 0, 32'h100, 3'd4, 0, 0, 0, 0, 0, rd, lat);
    chk("lw_data", rd, 32'h44332211);
    chk("lw_lat", lat, 5);
    for (int k = 0; k < 5; k++) chk("lw_addr", aq[k], 32'h100 + ((k < 3) ? k : 3));
    tick;
    chk("lw_pulse", mc_done, 0);

    // SH 0x202
    wq.delete();
    req(0, 1, 32'h202, 3'd2, 32'hAABBCCDD, 0, 0, 0, 0, rd, lat);
    ref_store(32'h202, 2, 32'hAABBCCDD);
    chk("sh_lat", lat, 2);
    chk("sh_nwr", wq.size(), 2);
    chk("sh_wr0", wq[0], {32'h202, 8'hDD});
    chk("sh_wr1", wq[1], {32'h203, 8'hCC});
    tick;
    chk("sh_pulse", mc_done, 0);
    chk("sh_nwr_after", wq.size(), 2);

    // LB and fetch raised together: LSB wins
    mc_en = 1'b1; mc_wr = 1'b0; mc_addr = 32'h10; mc_len = 3'd1;
    if_en = 1'b1; if_addr = 32'h0;
    cyc = 0;
    while (!mc_done && cyc < 50) begin tick; cyc++; end
    chk("arb_lb_edges", cyc, 3);
    chk("arb_lb_data", mc_r_data, {24'h0, ref_mem[12'h010]});
    chk("arb_if_early", if_done, 0);
    mc_en = 1'b0;
    cyc = 0;
    while (!if_done && cyc < 50) begin tick; cyc++; end
    chk("arb_if_edges", cyc, 6);
    chk("arb_if_data", if_data, ref_load(32'h0, 4));
    if_en = 1'b0;
    tick;
    chk("if_pulse", if_done, 0);

    // Rollback two cycles into a fetch, then an immediate new fetch
    snap = ifd_cnt;
    if_en = 1'b1; if_addr = 32'h40;
    tick; tick;
    rollback = 1'b1; if_en = 1'b0;
    tick;
    rollback = 1'b0;
    req(1, 0, 32'h40, 3'd4, 0, 0, 0, 0, 0, rd, lat);
    chk("rb_if_lat", lat, 5);
    chk("rb_if_data", rd, ref_load(32'h40, 4));
    tick;
    chk("rb_if_ndone", ifd_cnt, snap + 1);

    // Rollback during a SW is ignored
    wq.delete();
    req(0, 1, 32'h300, 3'd4, 32'hDEADBEEF, 0, 0, 1, 3, rd, lat);
    ref_store(32'h300, 4, 32'hDEADBEEF);
    chk("rb_sw_lat", lat, 4);
    chk("rb_sw_nwr", wq.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("rb_sw_wr", wq[k], {32'h300 + 32'(k), 8'(32'hDEADBEEF >> (8 * k))});

    // rdy low gates mem_wr and stalls the store
    wq.delete();
    mc_en = 1'b1; mc_wr = 1'b1; mc_addr = 32'h400; mc_len = 3'd4; mc_w_data = 32'h01020304;
    tick;
    chk("gate_wr_on", mem_wr, 1);
    rdy = 1'b0;
    #1;
    chk("gate_wr_off", mem_wr, 0);
    tick; tick;
    rdy = 1'b1;
    cyc = 0;
    while (!mc_done && cyc < 50) begin tick; cyc++; end
    mc_en = 1'b0;
    ref_store(32'h400, 4, 32'h01020304);
    chk("gate_nwr", wq.size(), 4);
    chk("gate_wr3", wq[3], {32'h403, 8'h01});

    // IO byte store with the FIFO full for three edges
    wq.delete();
    req(0, 1, 32'h30000, 3'd1, 32'h5A, 3, 0, 0, 0, rd, lat);
    ref_store(32'h30000, 1, 32'h5A);
`ifdef MEM_CTRL_IO_THROTTLE_EN
    chk("io_lat", lat, 4);
`else
    chk("io_lat", lat, 1);
`endif
    chk("io_nwr", wq.size(), 1);
    chk("io_wr", wq[0], {32'h30000, 8'h5A});

    // Asynchronous reset in the middle of a LW
    mc_en = 1'b1; mc_wr = 1'b0; mc_addr = 32'h100; mc_len = 3'd4;
    tick; tick;
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_a", mem_a, 0);
    chk("arst_rdata", mc_r_data, 0);
    chk("arst_done", mc_done, 0);
    mc_en = 1'b0;
    snap = mcd_cnt;
    tick;
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) tick;
    chk("arst_nodone", mcd_cnt, snap);
    req(0, 0, 32'h100, 3'd4, 0, 0, 0, 0, 0, rd, lat);
    chk("arst_lw_data", rd, ref_load(32'h100, 4));
    chk("arst_lw_lat", lat, 5);

    // Randomized traffic with random rdy stalls
    for (int it = 0; it < 80; it++) begin
      int op, n, w0;
      logic [31:0] a, wd;
      logic [2:0] ln;
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                       : 32'($urandom_range(0, 4095));
      ln = 3'($urandom_range(0, 7));
      n  = nlen(ln);
      wd = $urandom;
      if (op == 0) begin
        req(1, 0, a, 3'd4, 0, 0, 1, 0, 0, rd, lat);
        chk("rnd_fetch", rd, ref_load(a, 4));
      end else if (op == 1) begin
        req(0, 0, a, ln, 0, 0, 1, 0, 0, rd, lat);
        chk("rnd_load", rd, ref_load(a, n));
      end else begin
        w0 = wq.size();
        req(0, 1, a, ln, wd, 0, 1, 0, 0, rd, lat);
        ref_store(a, n, wd);
        chk("rnd_store_nwr", wq.size() - w0, n);
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) tick;
    end

    tick; tick;
    begin
      int diffs = 0;
      for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) diffs++;
      chk("ram_image", diffs, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
